register_bank_nz: RTL and testbench

//  Parametrised successor to the single accumulator: a bank of NUM_REGS WIDTH-bit CPU registers
//  (A, X, Y by default) with one opcode-driven write port and registered N/Z/C flag generation.

---
 rtl/register_bank_nz.sv | 114 +++++++++++
 tb/tb_register_bank_nz.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_nz.sv
// CPU register bank (accumulator at index 0) with one opcode write port.
// Registered N/Z/C flags and op_done / flag_c_vld pulses.
module register_bank_nz #(
  parameter int WIDTH = 8,
  parameter int NUM_REGS = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int SEL_W = (NUM_REGS == 1) ? 1 : $clog2(NUM_REGS)
) (
  input  logic             fclk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [SEL_W-1:0] dst_sel,
  input  logic [SEL_W-1:0] src_sel,
  input  logic             rotate,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] db_in,
  input  logic [WIDTH-1:0] alu_in,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_c_vld,
  output logic             op_done
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LD_DB  = 3'd1;
  localparam logic [2:0] OP_LD_ALU = 3'd2;
  localparam logic [2:0] OP_INC    = 3'd3;
  localparam logic [2:0] OP_DEC    = 3'd4;
  localparam logic [2:0] OP_XFER   = 3'd5;
  localparam logic [2:0] OP_SHL    = 3'd6;
  localparam logic [2:0] OP_SHR    = 3'd7;

  localparam logic [SEL_W:0] NREG = NUM_REGS[SEL_W:0];
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] regs [NUM_REGS];

  logic             dst_ok;
  logic             src_ok;
  logic             rd_ok;
  logic             accept;
  logic             shift_op;
  logic             fill;
  logic             c_new;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] res;

  assign dst_ok = {1'b0, dst_sel} < NREG;
  assign src_ok = {1'b0, src_sel} < NREG;
  assign rd_ok  = {1'b0, rd_sel} < NREG;

  assign accept = op_valid && (op_code != OP_NOP) && dst_ok &&
                  ((op_code != OP_XFER) || src_ok);

  assign cur  = dst_ok ? regs[dst_sel] : '0;
  assign src  = src_ok ? regs[src_sel] : '0;
  assign fill = rotate & carry_in;

  always_comb begin
    res      = cur;
    c_new    = flag_c;
    shift_op = 1'b0;
    unique case (op_code)
      OP_NOP:    res = cur;
      OP_LD_DB:  res = db_in;
      OP_LD_ALU: res = alu_in;
      OP_INC:    res = cur + ONE;
      OP_DEC:    res = cur - ONE;
      OP_XFER:   res = src;
      OP_SHL: begin
        res      = {cur[WIDTH-2:0], fill};
        c_new    = cur[WIDTH-1];
        shift_op = 1'b1;
      end
      OP_SHR: begin
        res      = {fill, cur[WIDTH-1:1]};
        c_new    = cur[0];
        shift_op = 1'b1;
      end
    endcase
  end

  always_ff @(posedge fclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      flag_n     <= RESET_VAL[WIDTH-1];
      flag_z     <= (RESET_VAL == '0);
      flag_c     <= 1'b0;
      flag_c_vld <= 1'b0;
      op_done    <= 1'b0;
    end else begin
      op_done    <= accept;
      flag_c_vld <= accept && shift_op;
      if (accept) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (dst_sel == SEL_W'(i)) regs[i] <= res;
        flag_n <= res[WIDTH-1];
        flag_z <= (res == '0);
        if (shift_op) flag_c <= c_new;
      end
    end
  end

  // no bypass: reads show the value stored at the last edge
  assign db_out  = rd_ok ? regs[rd_sel] : '0;
  assign alu_out = regs[0];

endmodule

// File: tb/tb_register_bank_nz.sv
// Directed bench for register_bank_nz: 8-bit/3-reg and 16-bit/4-reg builds.
// Expected values are hand-computed constants.
module tb_register_bank_nz;

  localparam logic [2:0] NOP = 3'd0, LDB = 3'd1, LDA = 3'd2, INC = 3'd3;
  localparam logic [2:0] DEC = 3'd4, XFR = 3'd5, SHL = 3'd6, SHR = 3'd7;

  logic fclk = 1'b0;
  logic reset = 1'b1;
  always #5 fclk = ~fclk;

  int n_vec = 0;
  int n_err = 0;

  // 8-bit, 3 registers
  logic       a_valid = 1'b0;
  logic [2:0] a_op = NOP;
  logic [1:0] a_dst = '0, a_src = '0, a_rd = '0;
  logic       a_rot = 1'b0, a_cin = 1'b0;
  logic [7:0] a_db = '0, a_alu = '0;
  logic [7:0] a_dbo, a_alo;
  logic       a_n, a_z, a_c, a_cv, a_done;

  register_bank_nz u_a (
    .fclk(fclk), .reset(reset), .op_valid(a_valid), .op_code(a_op),
    .dst_sel(a_dst), .src_sel(a_src), .rotate(a_rot), .carry_in(a_cin),
    .db_in(a_db), .alu_in(a_alu), .rd_sel(a_rd), .db_out(a_dbo),
    .alu_out(a_alo), .flag_n(a_n), .flag_z(a_z), .flag_c(a_c),
    .flag_c_vld(a_cv), .op_done(a_done)
  );

  // 16-bit, 4 registers
  logic        b_valid = 1'b0;
  logic [2:0]  b_op = NOP;
  logic [1:0]  b_dst = '0, b_src = '0, b_rd = '0;
  logic        b_rot = 1'b0, b_cin = 1'b0;
  logic [15:0] b_db = '0, b_alu = '0;
  logic [15:0] b_dbo, b_alo;
  logic        b_n, b_z, b_c, b_cv, b_done;

  register_bank_nz #(.WIDTH(16), .NUM_REGS(4)) u_b (
    .fclk(fclk), .reset(reset), .op_valid(b_valid), .op_code(b_op),
    .dst_sel(b_dst), .src_sel(b_src), .rotate(b_rot), .carry_in(b_cin),
    .db_in(b_db), .alu_in(b_alu), .rd_sel(b_rd), .db_out(b_dbo),
    .alu_out(b_alo), .flag_n(b_n), .flag_z(b_z), .flag_c(b_c),
    .flag_c_vld(b_cv), .op_done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic a_issue(input logic [2:0] op, input logic [1:0] dst,
                         input logic [1:0] src, input logic rot,
                         input logic cin, input logic [7:0] db);
    a_valid = 1'b1; a_op = op; a_dst = dst; a_src = src;
    a_rot = rot; a_cin = cin; a_db = db;
    @(posedge fclk); #1;
  endtask

  task automatic b_issue(input logic [2:0] op, input logic [1:0] dst,
                         input logic [1:0] src, input logic rot,
                         input logic cin, input logic [15:0] val);
    b_valid = 1'b1; b_op = op; b_dst = dst; b_src = src;
    b_rot = rot; b_cin = cin; b_db = val; b_alu = val;
    @(posedge fclk); #1;
  endtask

  task automatic idle;
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge fclk); #1;
  endtask

  task automatic a_read(input string tag, input logic [1:0] sel,
                        input logic [7:0] exp);
    a_rd = sel; #1;
    check(tag, 32'(a_dbo), 32'(exp));
  endtask

  task automatic b_read(input string tag, input logic [1:0] sel,
                        input logic [15:0] exp);
    b_rd = sel; #1;
    check(tag, 32'(b_dbo), 32'(exp));
  endtask

  task automatic a_flags(input string tag, input logic n, input logic z,
                         input logic c, input logic cv, input logic done);
    check(tag, {27'd0, a_n, a_z, a_c, a_cv, a_done},
          {27'd0, n, z, c, cv, done});
  endtask

  task automatic b_flags(input string tag, input logic n, input logic z,
                         input logic c, input logic cv, input logic done);
    check(tag, {27'd0, b_n, b_z, b_c, b_cv, b_done},
          {27'd0, n, z, c, cv, done});
  endtask

  initial begin
    // T1: op presented during reset must be ignored
    a_valid = 1'b1; a_op = LDB; a_dst = 2'd0; a_db = 8'h55;
    b_valid = 1'b1; b_op = LDB; b_dst = 2'd3; b_db = 16'h1234;
    repeat (2) @(posedge fclk);
    #1;
    check("t1_acc", 32'(a_alo), 32'h00);
    a_flags("t1_flags", 0, 1, 0, 0, 0);
    a_read("t1_r1", 2'd1, 8'h00);
    b_read("t1_b3", 2'd3, 16'h0000);
    b_flags("t1_bflags", 0, 1, 0, 0, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b0;
    idle();
    a_flags("t1_post", 0, 1, 0, 0, 0);

    // T2: load then transfer into accumulator
    a_issue(LDB, 2'd1, 2'd0, 0, 0, 8'h80);
    a_flags("t2_ld_flags", 1, 0, 0, 0, 1);
    a_read("t2_r1", 2'd1, 8'h80);
    a_issue(XFR, 2'd0, 2'd1, 0, 0, 8'h00);
    check("t2_acc", 32'(a_alo), 32'h80);
    a_flags("t2_xf_flags", 1, 0, 0, 0, 1);
    idle();
    a_flags("t2_done_low", 1, 0, 0, 0, 0);

    // T3: INC wrap and DEC wrap, carry untouched
    a_issue(LDB, 2'd2, 2'd0, 0, 0, 8'hFF);
    a_issue(INC, 2'd2, 2'd0, 0, 0, 8'h00);
    a_read("t3_inc", 2'd2, 8'h00);
    a_flags("t3_inc_flags", 0, 1, 0, 0, 1);
    a_issue(DEC, 2'd2, 2'd0, 0, 0, 8'h00);
    a_read("t3_dec", 2'd2, 8'hFF);
    a_flags("t3_dec_flags", 1, 0, 0, 0, 1);

    // T4: rotate-left through carry, shift-right with zero fill
    a_issue(LDB, 2'd0, 2'd0, 0, 0, 8'h81);
    a_issue(SHL, 2'd0, 2'd0, 1, 1, 8'h00);
    check("t4_shl", 32'(a_alo), 32'h03);
    a_flags("t4_shl_flags", 0, 0, 1, 1, 1);
    a_issue(LDB, 2'd1, 2'd0, 0, 0, 8'h01);
    a_flags("t4_ld_cv", 0, 0, 1, 0, 1);
    a_issue(SHR, 2'd1, 2'd0, 0, 0, 8'h00);
    a_read("t4_shr", 2'd1, 8'h00);
    a_flags("t4_shr_flags", 0, 1, 1, 1, 1);
    a_issue(SHR, 2'd1, 2'd0, 1, 1, 8'h00);
    a_read("t4_ror", 2'd1, 8'h80);
    a_flags("t4_ror_flags", 1, 0, 0, 1, 1);

    // T5: out-of-range selects and unqualified ops change nothing
    a_issue(LDB, 2'd3, 2'd0, 0, 0, 8'h12);
    a_flags("t5_bad_dst", 1, 0, 0, 0, 0);
    a_issue(XFR, 2'd0, 2'd3, 0, 0, 8'h00);
    a_flags("t5_bad_src", 1, 0, 0, 0, 0);
    check("t5_acc", 32'(a_alo), 32'h03);
    a_read("t5_rd3", 2'd3, 8'h00);
    a_valid = 1'b0; a_op = LDB; a_dst = 2'd0; a_db = 8'h00;
    @(posedge fclk); #1;
    check("t5_noval", 32'(a_alo), 32'h03);
    a_flags("t5_noval_fl", 1, 0, 0, 0, 0);
    a_issue(NOP, 2'd0, 2'd0, 0, 0, 8'h00);
    a_flags("t5_nop", 1, 0, 0, 0, 0);
    a_valid = 1'b0;

    // T6: 16-bit build, back-to-back INC across the wrap
    b_issue(LDB, 2'd3, 2'd0, 0, 0, 16'hFFFE);
    b_issue(INC, 2'd3, 2'd0, 0, 0, 16'h0000);
    b_read("t6_inc1", 2'd3, 16'hFFFF);
    b_flags("t6_inc1_fl", 1, 0, 0, 0, 1);
    b_issue(INC, 2'd3, 2'd0, 0, 0, 16'h0000);
    b_read("t6_inc2", 2'd3, 16'h0000);
    b_flags("t6_inc2_fl", 0, 1, 0, 0, 1);
    b_issue(INC, 2'd3, 2'd0, 0, 0, 16'h0000);
    b_read("t6_inc3", 2'd3, 16'h0001);
    b_issue(SHL, 2'd3, 2'd0, 0, 1, 16'h0000);
    b_read("t6_shl", 2'd3, 16'h0002);
    b_flags("t6_shl_fl", 0, 0, 0, 1, 1);
    b_issue(LDA, 2'd2, 2'd0, 0, 0, 16'h8001);
    b_read("t6_lda", 2'd2, 16'h8001);
    b_issue(SHR, 2'd2, 2'd0, 1, 0, 16'h0000);
    b_read("t6_shr", 2'd2, 16'h4000);
    b_flags("t6_shr_fl", 0, 0, 1, 1, 1);
    b_issue(XFR, 2'd0, 2'd2, 0, 0, 16'h0000);
    check("t6_acc", 32'(b_alo), 32'h4000);
    b_flags("t6_xfr_fl", 0, 0, 1, 0, 1);
    b_issue(XFR, 2'd3, 2'd3, 0, 0, 16'h0000);
    b_read("t6_self", 2'd3, 16'h0002);
    idle();
    b_flags("t6_idle", 0, 0, 1, 0, 0);

    // reset again with a write in flight
    a_issue(LDB, 2'd0, 2'd0, 0, 0, 8'hAA);
    reset = 1'b1;
    a_issue(LDB, 2'd0, 2'd0, 0, 0, 8'hF0);
    check("rst2_acc", 32'(a_alo), 32'h00);
    a_flags("rst2_flags", 0, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
